// File: rtl/dp_pd_packer.sv
// Width-converting packer: concatenates up to RATIO narrow pd beats into one
// wide registered output beat, with early close via in_last and a lane mask.
module dp_pd_packer #(
  parameter int unsigned PW    = 32,
  parameter int unsigned RATIO = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PW-1:0]         in_pd,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW*RATIO-1:0]   out_pd,
  output logic [RATIO-1:0]      out_mask,
  output logic                  out_last
);

  localparam int unsigned CW   = $clog2(RATIO);
  localparam int unsigned OW   = PW * RATIO;
  localparam int unsigned AW   = PW * (RATIO - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [OW-1:0]    out_pd_q, out_pd_d;
  logic [RATIO-1:0] out_mask_q, out_mask_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             in_fire;
  logic             completing;

  // A held output beat blocks input unless it is being drained this cycle.
  assign in_ready   = !out_valid_q || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign completing = in_fire && ((cnt_q == CNT_MAX) || in_last);

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_pd_d    = out_pd_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire && !completing) begin
      for (int i = 0; i < int'(RATIO) - 1; i++) begin
        if (CW'(i) == cnt_q) begin
          acc_d[i*PW +: PW] = in_pd;
        end
      end
      cnt_d = cnt_q + CW'(1);
    end

    // Lanes below cnt come from the accumulator, lane cnt is the closing beat.
    if (completing) begin
      out_pd_d = '0;
      for (int i = 0; i < int'(RATIO) - 1; i++) begin
        if (CW'(i) < cnt_q) begin
          out_pd_d[i*PW +: PW] = acc_q[i*PW +: PW];
        end
      end
      for (int i = 0; i < int'(RATIO); i++) begin
        if (CW'(i) == cnt_q) begin
          out_pd_d[i*PW +: PW] = in_pd;
        end
        out_mask_d[i] = (CW'(i) <= cnt_q);
      end
      out_last_d  = in_last;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_pd_q    <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_pd_q    <= out_pd_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pd    = out_pd_q;
  assign out_mask  = out_mask_q;
  assign out_last  = out_last_q;

endmodule
